// File: rtl/ddr_line_adapter.sv
// ddr_line_adapter: 128-bit line request stream to DDR3 user-port commands, with ordered read responses.
// Optional DDR_ADAPTER_STATS_EN adds stat_rd/stat_wr/stat_stall counters.
module ddr_line_adapter #(
  parameter int RSP_DEPTH   = 8,
  parameter int MAX_WR_PEND = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [31:0]  cmd_addr,
  input  logic [127:0] cmd_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         wr_idle,
  output logic         rd_addr_en,
  output logic [31:0]  rd_addr,
  output logic         rd_en,
  input  logic         rd_valid,
  input  logic [127:0] rd_data,
  input  logic         rd_busy,
  output logic         wr_addr_en,
  output logic         wr_en,
  output logic [31:0]  wr_addr,
  output logic [127:0] wr_data,
  output logic [15:0]  wr_datamask,
  input  logic         wr_ack,
  input  logic         wr_busy
`ifdef DDR_ADAPTER_STATS_EN
  ,
  output logic [31:0]  stat_rd,
  output logic [31:0]  stat_wr,
  output logic [31:0]  stat_stall
`endif
);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;
  localparam int WPW = $clog2(MAX_WR_PEND + 1);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_nx;
  logic [CW-1:0]  rd_out, count;
  logic [CW:0]    credit_sum;
  logic [PW-1:0]  wptr, rptr;
  logic [WPW-1:0] wr_pend;
  logic [127:0]   mem [RSP_DEPTH];
  logic dir_ok, credit_ok, accept, acc_rd, acc_wr, push, pop, ack;
  logic unused;
  assign unused = ^cmd_addr[3:0];
  always_comb begin
    credit_sum  = {1'b0, rd_out} + {1'b0, count};
    dir_ok      = state == IDLE || (state == RD && !cmd_write) || (state == WR && cmd_write);
    credit_ok   = cmd_write ? (!wr_busy && wr_pend < WPW'(MAX_WR_PEND))
                            : (!rd_busy && credit_sum < (CW+1)'(RSP_DEPTH));
    cmd_ready   = !reset && dir_ok && credit_ok;
    accept      = cmd_valid && cmd_ready;
    acc_rd      = accept && !cmd_write;
    acc_wr      = accept && cmd_write;
    rd_en       = !reset && rd_valid && count < CW'(RSP_DEPTH);
    // Data returned with no read outstanding is stray and must not enter the FIFO.
    push        = rd_en && rd_out != '0;
    rsp_valid   = count != '0;
    pop         = rsp_valid && rsp_ready;
    ack         = wr_ack && wr_pend != '0;
    wr_idle     = wr_pend == '0;
    rsp_data    = rsp_valid ? mem[rptr] : '0;
    wr_datamask = '0;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept) state_nx = cmd_write ? WR : RD;
    else if (state == RD && rd_out == '0 && !accept) state_nx = IDLE;
    else if (state == WR && wr_pend == '0 && !accept) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_out     <= '0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      wr_pend    <= '0;
      rd_addr_en <= 1'b0;
      rd_addr    <= '0;
      wr_addr_en <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nx;
      rd_out     <= rd_out + CW'(acc_rd) - CW'(push);
      count      <= count + CW'(push) - CW'(pop);
      wptr       <= wptr + PW'(push);
      rptr       <= rptr + PW'(pop);
      wr_pend    <= wr_pend + WPW'(acc_wr) - WPW'(ack);
      rd_addr_en <= acc_rd;
      wr_addr_en <= acc_wr;
      wr_en      <= acc_wr;
      if (acc_rd) rd_addr <= {4'b0, cmd_addr[31:4]};
      if (acc_wr) begin
        wr_addr <= {4'b0, cmd_addr[31:4]};
        wr_data <= cmd_wdata;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rd_data;
  end
`ifdef DDR_ADAPTER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd    <= '0;
      stat_wr    <= '0;
      stat_stall <= '0;
    end else begin
      stat_rd    <= stat_rd + 32'(acc_rd);
      stat_wr    <= stat_wr + 32'(acc_wr);
      stat_stall <= stat_stall + 32'(cmd_valid && !cmd_ready);
    end
  end
`endif
endmodule

// File: tb/tb_ddr_line_adapter.sv
// tb_ddr_line_adapter: directed bench for ddr_line_adapter with a small DDR3 user-port responder.
module tb_ddr_line_adapter;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [127:0] cmd_wdata;
  logic rsp_valid, rsp_ready, wr_idle;
  logic [127:0] rsp_data;
  logic rd_addr_en, rd_en, rd_valid, rd_busy;
  logic [31:0] rd_addr;
  logic [127:0] rd_data;
  logic wr_addr_en, wr_en, wr_ack, wr_busy;
  logic [31:0] wr_addr;
  logic [127:0] wr_data;
  logic [15:0] wr_datamask;
`ifdef DDR_ADAPTER_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_stall;
`endif
  always #5 clk = ~clk;
  ddr_line_adapter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .wr_idle(wr_idle), .rd_addr_en(rd_addr_en), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_busy(rd_busy), .wr_addr_en(wr_addr_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_datamask(wr_datamask), .wr_ack(wr_ack), .wr_busy(wr_busy)
`ifdef DDR_ADAPTER_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_stall(stat_stall)
`endif
  );
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Controller model: stores writes, acks them a cycle later, returns reads in order.
  logic [127:0] mem [logic [31:0]];
  logic [31:0] rq [$];
  int ack_pending = 0;
  bit ack_hold = 0, rd_hold = 0, took = 0;
  initial begin
    rd_valid = 0; rd_data = '0; wr_ack = 0;
    forever begin
      @(negedge clk);
      if (took && rq.size() > 0) void'(rq.pop_front());
      wr_ack = ack_pending > 0 && !ack_hold;
      if (wr_ack) ack_pending--;
      if (wr_en) begin mem[wr_addr] = wr_data; ack_pending++; end
      if (rd_addr_en) rq.push_back(rd_addr);
      rd_valid = rq.size() > 0 && !rd_hold;
      rd_data = rd_valid ? (mem.exists(rq[0]) ? mem[rq[0]] : {4{rq[0]}}) : '0;
      #1 took = rd_valid && rd_en;
    end
  end
  task automatic send(input bit w, input logic [31:0] a, input logic [127:0] d, input string tag);
    bit ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 if (cmd_ready) ok = 1;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 0;
    chk({tag, "_acc"}, 128'(ok), 1);
  endtask
  task automatic get(input logic [127:0] exp, input string tag);
    bit ok = 0;
    logic [127:0] d = '0;
    rsp_ready = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 if (rsp_valid) begin ok = 1; d = rsp_data; end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 0;
    chk({tag, "_vld"}, 128'(ok), 1);
    chk(tag, d, exp);
  endtask
  task automatic stall(input bit w, input logic [31:0] a, input int n, input string tag);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = '1;
    for (int i = 0; i < n; i++) begin
      #1 chk(tag, 128'(cmd_ready), 0);
      @(negedge clk);
    end
    cmd_valid = 0;
  endtask
  initial begin
    #200000 $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [127:0] a_dat, b_dat;
    logic [31:0] v;
    a_dat = 128'h0123456789abcdef_fedcba9876543210;
    b_dat = 128'hcafef00d_deadbeef_11223344_55667788;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; rd_busy = 0; wr_busy = 0;
    repeat (3) @(negedge clk);
    cmd_valid = 1;
    #1 chk("rst_ready", 128'(cmd_ready), 0);
    chk("rst_rsp_valid", 128'(rsp_valid), 0);
    chk("rst_wr_idle", 128'(wr_idle), 1);
    chk("rst_rd_addr_en", 128'(rd_addr_en), 0);
    chk("rst_wr_en", 128'(wr_en), 0);
    chk("rst_wr_addr", 128'(wr_addr), 0);
    cmd_valid = 0;
    @(negedge clk) reset = 0;
    @(negedge clk);
    // write then read same line; read must wait for wr_ack
    ack_hold = 1;
    send(1, 32'h100, a_dat, "t1_wr");
    chk("t1_wr_en", 128'(wr_en), 1);
    chk("t1_wr_addr_en", 128'(wr_addr_en), 1);
    chk("t1_wr_addr", 128'(wr_addr), 128'h10);
    chk("t1_wr_data", wr_data, a_dat);
    chk("t1_wr_mask", 128'(wr_datamask), 0);
    chk("t1_wr_idle0", 128'(wr_idle), 0);
    stall(0, 32'h100, 3, "t1_rd_stall");
    chk("t1_no_rd", 128'(rd_addr_en), 0);
    ack_hold = 0;
    send(0, 32'h100, '0, "t1_rd");
    chk("t1_wr_idle1", 128'(wr_idle), 1);
    chk("t1_rd_addr_en", 128'(rd_addr_en), 1);
    chk("t1_rd_addr", 128'(rd_addr), 128'h10);
    get(a_dat, "t1_rsp");
    // credit limit: 8 reads fill FIFO, 9th stalls until a pop
    for (int i = 0; i < 8; i++) send(0, 32'h1000 + 32'(16 * i), '0, "t2_rd");
    repeat (5) @(negedge clk);
    chk("t2_rsp_valid", 128'(rsp_valid), 1);
    stall(0, 32'h1080, 3, "t2_stall9");
    get({4{32'h100}}, "t2_rsp0");
    send(0, 32'h1080, '0, "t2_rd9");
    for (int i = 1; i < 9; i++) begin
      v = 32'h100 + 32'(i);
      get({4{v}}, "t2_rsp");
    end
    // read, write, read: write waits for read data; responses in order
    rd_hold = 1;
    send(0, 32'h200, '0, "t3_rd1");
    stall(1, 32'h300, 3, "t3_wr_stall");
    rd_hold = 0;
    send(1, 32'h300, b_dat, "t3_wr");
    chk("t3_rsp1_pushed", 128'(rsp_valid), 1);
    send(0, 32'h300, '0, "t3_rd2");
    get({4{32'h20}}, "t3_rsp1");
    get(b_dat, "t3_rsp2");
    // busy ports block only their own direction
    rd_busy = 1;
    stall(0, 32'h400, 3, "t4_rd_busy");
    chk("t4_no_rd", 128'(rd_addr_en), 0);
    cmd_valid = 1; cmd_write = 1;
    #1 chk("t4_wr_ok", 128'(cmd_ready), 1);
    cmd_valid = 0;
    rd_busy = 0; wr_busy = 1;
    @(negedge clk);
    stall(1, 32'h400, 3, "t4_wr_busy");
    chk("t4_no_wr", 128'(wr_en), 0);
    cmd_valid = 1; cmd_write = 0;
    #1 chk("t4_rd_ok", 128'(cmd_ready), 1);
    cmd_valid = 0;
    wr_busy = 0;
    @(negedge clk);
    // reset with read data buffered and writes awaiting ack
    rd_hold = 1;
    for (int i = 0; i < 3; i++) send(0, 32'h600 + 32'(16 * i), '0, "t5_rd");
    rd_hold = 0;
    repeat (5) @(negedge clk);
    chk("t5_buffered", 128'(rsp_valid), 1);
    ack_hold = 1;
    send(1, 32'h700, a_dat, "t5_wr0");
    send(1, 32'h710, b_dat, "t5_wr1");
    chk("t5_wr_pend", 128'(wr_idle), 0);
    #2 reset = 1;
    #1 chk("t5_rst_ready", 128'(cmd_ready), 0);
    chk("t5_rst_rsp_valid", 128'(rsp_valid), 0);
    chk("t5_rst_wr_idle", 128'(wr_idle), 1);
    chk("t5_rst_wr_en", 128'(wr_en), 0);
    chk("t5_rst_wr_addr", 128'(wr_addr), 0);
    chk("t5_rst_wr_data", wr_data, 0);
    chk("t5_rst_rd_en", 128'(rd_en), 0);
    rq.delete();
    ack_pending = 0; took = 0; ack_hold = 0;
    @(negedge clk) reset = 0;
    @(negedge clk);
    chk("t5_post_rsp_valid", 128'(rsp_valid), 0);
    send(0, 32'h5000, '0, "t5_rd_fresh");
    get({4{32'h500}}, "t5_rsp");
`ifdef DDR_ADAPTER_STATS_EN
    chk("stat_rd", 128'(stat_rd), 1);
    chk("stat_wr", 128'(stat_wr), 0);
    chk("stat_stall", 128'(stat_stall), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
